mem_arbiter: RTL and testbench

Arbiter and sequencer that shares the single-port `Memory` between the instruction-fetch requester and the data (load/store) requester of the datapath. It grants one requester at a time and drives `Memory`'s `ren`/`wen`/`addr`/`din`, so that `ren` and `wen` are never active together. It returns read data through a registered response with a one-cycle acknowledge. Data accesses have priority over fetch, with an optional starvation guard for fetch.

---
 rtl/mem_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares the single-port Memory between the fetch and data requesters. Data has priority over fetch.
// Define MEM_ARB_STARVE_GUARD_EN to build in the fetch starvation guard (counter limit set by STARVE_LIMIT).
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout,
    output logic        busy
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t state;
    logic   sel_d;
    logic   force_fetch_c;
    logic   grant_d_c;
    logic   grant_if_c;

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [CW-1:0] starve_cnt;

    assign force_fetch_c = (starve_cnt == CW'(STARVE_LIMIT));

    // Counts data grants won while fetch waits; cleared once fetch is served or stops asking.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (grant_if_c || !if_req) begin
                starve_cnt <= '0;
            end else if (grant_d_c && (starve_cnt != CW'(STARVE_LIMIT))) begin
                starve_cnt <= starve_cnt + CW'(1);
            end
        end
    end
`else
    logic unused_starve_limit;

    assign unused_starve_limit = |CW'(STARVE_LIMIT);
    assign force_fetch_c       = 1'b0;
`endif

    assign grant_d_c  = d_req && !(if_req && force_fetch_c);
    assign grant_if_c = if_req && !grant_d_c;

    // Sequencer: IDLE arbitrates and latches, ACCESS drives Memory, RESP acknowledges.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            sel_d    <= 1'b0;
            mem_ren  <= 1'b0;
            mem_wen  <= 1'b0;
            mem_addr <= AW'(0);
            mem_din  <= DW'(0);
            if_rdata <= DW'(0);
            d_rdata  <= DW'(0);
            if_ack   <= 1'b0;
            d_ack    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d_c || grant_if_c) begin
                        state    <= ACCESS;
                        busy     <= 1'b1;
                        sel_d    <= grant_d_c;
                        mem_addr <= grant_d_c ? d_addr : if_addr;
                        if (grant_d_c) begin
                            mem_din <= d_wdata;
                        end
                        // Fetch grants never write, whatever d_we says.
                        mem_wen  <= grant_d_c && d_we;
                        mem_ren  <= !(grant_d_c && d_we);
                    end
                end
                ACCESS: begin
                    state   <= RESP;
                    mem_ren <= 1'b0;
                    mem_wen <= 1'b0;
                    if (sel_d) begin
                        d_ack <= 1'b1;
                        if (mem_ren) begin
                            d_rdata <= mem_dout;
                        end
                    end else begin
                        if_ack   <= 1'b1;
                        if_rdata <= mem_dout;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    mem_ren <= 1'b0;
                    mem_wen <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a negedge-write word memory model.
// Guard expectations follow MEM_ARB_STARVE_GUARD_EN at compile time.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int acc44 = 0;
    int if_ack_cnt = 0;

    logic [31:0] mem [256];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_idx = '0;
    logic [31:0] pl_val = '0;
    logic [31:0] exp_d = '0;

    mem_arbiter #(.STARVE_LIMIT(2)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .busy(busy)
    );

    always #5 clock = ~clock;

    assign mem_dout = mem[mem_addr[9:2]];

    always @(negedge clock) begin
        if (mem_wen) mem[mem_addr[9:2]] <= mem_din;
        else if (pl_en) mem[pl_idx] <= pl_val;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Exclusive ren/wen and per-port activity bookkeeping.
    always @(negedge clock) begin
        check("ren_wen_excl", 32'(mem_ren & mem_wen), 32'd0);
        if ((mem_ren || mem_wen) && mem_addr == 32'h44) acc44++;
        if (if_ack) if_ack_cnt++;
    end

    task automatic preload(input logic [7:0] idx, input logic [31:0] val);
        @(posedge clock);
        pl_en = 1'b1; pl_idx = idx; pl_val = val;
        @(posedge clock);
        pl_en = 1'b0;
    endtask

    // One complete transaction on a single port, checked cycle by cycle.
    task automatic xfer(input string tag, input logic use_d, input logic we,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] exp);
        @(negedge clock);
        if (use_d) begin d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; end
        else begin if_req = 1'b1; if_addr = addr; d_we = we; end
        @(posedge clock); #1;
        check({tag, ".ren"}, 32'(mem_ren), 32'(!(use_d && we)));
        check({tag, ".wen"}, 32'(mem_wen), 32'(use_d && we));
        check({tag, ".addr"}, mem_addr, addr);
        check({tag, ".busy"}, 32'(busy), 32'd1);
        if (use_d && we) check({tag, ".din"}, mem_din, wdata);
        @(posedge clock); #1;
        check({tag, ".ren_off"}, 32'({mem_ren, mem_wen}), 32'd0);
        check({tag, ".d_ack"}, 32'(d_ack), 32'(use_d));
        check({tag, ".if_ack"}, 32'(if_ack), 32'(!use_d));
        if (use_d) begin
            if (!we) exp_d = exp;
            check({tag, ".d_rdata"}, d_rdata, exp_d);
        end else begin
            check({tag, ".if_rdata"}, if_rdata, exp);
        end
        d_req = 1'b0; if_req = 1'b0; d_we = 1'b0;
        @(posedge clock); #1;
        check({tag, ".ack_off"}, 32'({d_ack, if_ack}), 32'd0);
        check({tag, ".idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [5:0] order;
        logic [5:0] exp_order;
        int n_acks;
        int base_if;

        // Reset values
        preload(8'd4, 32'h8C010004);
        preload(8'd12, 32'hAAAA5555);
        #1;
        check("rst.ctrl", 32'({mem_ren, mem_wen, if_ack, d_ack, busy}), 32'd0);
        check("rst.addr", mem_addr, 32'd0);
        check("rst.rdata", if_rdata | d_rdata | mem_din, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        xfer("fetch", 1'b0, 1'b0, 32'h10, 32'h0, 32'h8C010004);
        xfer("store", 1'b1, 1'b1, 32'h20, 32'hDEADBEEF, 32'h0);
        check("store.mem", mem[8], 32'hDEADBEEF);
        xfer("load", 1'b1, 1'b0, 32'h20, 32'h0, 32'hDEADBEEF);
        xfer("fetch_hi", 1'b0, 1'b1, 32'hFFFF_FC10, 32'h0, 32'h8C010004);

        // Simultaneous requests: data first, fetch three cycles later
        @(negedge clock);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        if_req = 1'b1; if_addr = 32'h10;
        @(posedge clock); #1;
        check("sim.d_addr", mem_addr, 32'h20);
        @(posedge clock); #1;
        check("sim.d_ack", 32'({d_ack, if_ack}), 32'b10);
        check("sim.d_rdata", d_rdata, 32'hDEADBEEF);
        d_req = 1'b0;
        @(posedge clock); #1;
        check("sim.gap", 32'({busy, if_ack}), 32'd0);
        @(posedge clock); #1;
        check("sim.if_addr", mem_addr, 32'h10);
        check("sim.if_ren", 32'(mem_ren), 32'd1);
        @(posedge clock); #1;
        check("sim.if_ack", 32'({d_ack, if_ack}), 32'b01);
        check("sim.if_rdata", if_rdata, 32'h8C010004);
        if_req = 1'b0;
        @(posedge clock); #1;

        // Fetch withdrawn while data is being served
        base_if = if_ack_cnt;
        @(negedge clock);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        if_req = 1'b1; if_addr = 32'h44;
        @(posedge clock); #1;
        if_req = 1'b0;
        @(posedge clock); #1;
        check("wd.d_ack", 32'(d_ack), 32'd1);
        d_req = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        check("wd.no_if_ack", 32'(if_ack_cnt - base_if), 32'd0);
        check("wd.no_access", 32'(acc44), 32'd0);

        // Both held high: ack order d=0, i=1, oldest in MSB
        @(negedge clock);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        if_req = 1'b1; if_addr = 32'h10;
        order = '0; n_acks = 0;
        for (int c = 0; c < 40 && n_acks < 6; c++) begin
            @(posedge clock); #1;
            if (d_ack || if_ack) begin
                order = {order[4:0], if_ack};
                n_acks++;
            end
        end
        d_req = 1'b0; if_req = 1'b0;
`ifdef MEM_ARB_STARVE_GUARD_EN
        exp_order = 6'b001001;
`else
        exp_order = 6'b000000;
`endif
        check("guard.n_acks", 32'(n_acks), 32'd6);
        check("guard.order", 32'(order), 32'(exp_order));
        repeat (3) @(posedge clock);

        // Reset in ACCESS before the negedge aborts the store
        @(negedge clock);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h30; d_wdata = 32'h12345678;
        @(posedge clock); #1;
        check("abort.wen_on", 32'(mem_wen), 32'd1);
        #1 reset = 1'b0;
        #1;
        check("abort.ctrl", 32'({mem_ren, mem_wen, if_ack, d_ack, busy}), 32'd0);
        check("abort.bus", mem_addr | mem_din, 32'd0);
        check("abort.rdata", if_rdata | d_rdata, 32'd0);
        d_req = 1'b0; d_we = 1'b0;
        @(negedge clock);
        #1;
        check("abort.mem", mem[12], 32'hAAAA5555);
        reset = 1'b1;
        repeat (3) begin
            @(posedge clock); #1;
            check("abort.no_ack", 32'({d_ack, if_ack, busy}), 32'd0);
        end
        exp_d = 32'h0;
        xfer("post_rst", 1'b0, 1'b0, 32'h30, 32'h0, 32'hAAAA5555);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
